// File: rtl/fpu_op_sequencer.sv
// Issue/collect stage for the free-running fpu adder: queues operand pairs, holds each one for a
// fixed settle window, then presents the sampled result. Define STATUS_STICKY_EN for sticky_status.
module fpu_op_sequencer #(
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned SETTLE_CYCLES = 64
) (
   input  logic        clock100KHz,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_op_a,
   input  logic [31:0] in_op_b,
   output logic [31:0] fpu_op_a,
   output logic [31:0] fpu_op_b,
   input  logic [31:0] fpu_data_in,
   input  logic [3:0]  fpu_status_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_status,
   output logic        busy,
   input  logic        sticky_clear,
   output logic [3:0]  sticky_status
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StPresent
   } state_e;

   // Operand FIFO
   logic [63:0]     mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push;
   logic            pop;
   logic [63:0]     head;

   // Issue/collect state
   state_e          state_q, state_d;
   logic [SetW-1:0] cnt_q, cnt_d;
   logic [31:0]     op_a_q, op_a_d;
   logic [31:0]     op_b_q, op_b_d;
   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_data_q, out_data_d;
   logic [3:0]      out_status_q, out_status_d;

   assign in_ready = (count_q != CntW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {in_op_a, in_op_b};
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_status_d = out_status_q;
      pop          = 1'b0;
      case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               op_a_d  = head[63:32];
               op_b_d  = head[31:0];
               cnt_d   = SetW'(SETTLE_CYCLES - 1);
               state_d = StSettle;
            end
         end
         StSettle: begin
            // The core has no done flag; sampling happens only once the window has elapsed.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - SetW'(1);
            end else begin
               out_data_d   = fpu_data_in;
               out_status_d = fpu_status_in;
               out_valid_d  = 1'b1;
               state_d      = StPresent;
            end
         end
         StPresent: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_status_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_status_q <= out_status_d;
      end
   end

   assign fpu_op_a   = op_a_q;
   assign fpu_op_b   = op_b_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_status = out_status_q;
   assign busy       = (state_q != StIdle);

`ifdef STATUS_STICKY_EN
   logic [3:0] sticky_q, sticky_d;

   always_comb begin
      sticky_d = sticky_q;
      // Clear wins over an accept in the same cycle.
      if (sticky_clear) begin
         sticky_d = 4'b0000;
      end else if (out_valid_q && out_ready) begin
         sticky_d = sticky_q | out_status_q;
      end
   end

   always_ff @(posedge clock100KHz or negedge reset) begin
      if (!reset) begin
         sticky_q <= 4'b0000;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_status = sticky_q;
`else
   logic unused_sticky_clear;
   assign unused_sticky_clear = sticky_clear;
   assign sticky_status       = 4'b0000;
`endif

endmodule
